inst_fetch: RTL
===============

// Module: inst_fetch
// PURPOSE
//  Program-counter / fetch-control stage directly upstream of the instruction ROM.
//  Owns the PC and drives InstAddress into the ROM every cycle.
//  Sequences program start, sequential fetch, relative branch, absolute jump, stall and halt.
//  Reports Done to the testbench and a saturating cycle count.
// PARAMETERS
//  A   16  instruction address width; must match the ROM address width
//  OW  8   width of the signed relative-branch offset
//  NP  4   number of selectable programs (entries in PROG_BASE)
//  CW  16  width of CycleCnt
// PORTS
//  Clk         in   1         rising-edge clock
//  Reset_n     in   1         asynchronous, active-low reset
//  Start       in   1         pulse: begin the program chosen by ProgSel
//  ProgSel     in   $clog2(NP) program index into fetch_pkg::PROG_BASE
//  Stall       in   1         hold the PC this cycle
//  BranchEn    in   1         take the relative branch this cycle
//  BranchOff   in   OW        signed offset, relative to the current PC
//  JumpEn      in   1         take the absolute jump this cycle
//  JumpAddr    in   A         absolute target address
//  HaltReq     in   1         the current instruction is HALT
//  InstAddress out  A         PC; drives the ROM address port
//  Valid       out  1         InstAddress holds a live fetch (state RUN)
//  Done        out  1         program finished; high in state HALTED
//  CycleCnt    out  CW        number of cycles spent in RUN
// BEHAVIOUR
//  - Reset (Reset_n=0, async, any state): PC=0, state=IDLE, Valid=0, Done=0, CycleCnt=0.
//  - Outputs are registered. Valid = (state==RUN). Done = (state==HALTED).
//  - FSM states: IDLE, RUN, HALTED (enum in fetch_pkg).
//  - IDLE:
//      Start=1 -> PC<=PROG_BASE[ProgSel], CycleCnt<=0, next state RUN.
//      All other inputs ignored.
//  - RUN: the next-PC source follows this fixed priority:
//      1 HaltReq  -> state HALTED; PC holds (stays on the HALT instruction).
//      2 Stall    -> PC holds. Branch and jump inputs are dropped, not queued.
//      3 JumpEn   -> PC<=JumpAddr.
//      4 BranchEn -> PC<=PC+sext(BranchOff), modulo 2^A.
//      5 default  -> PC<=PC+1, modulo 2^A (0xFFFF wraps to 0x0000 when A=16).
//      If JumpEn and BranchEn are both high, the jump wins.
//      Start is ignored in RUN; there is no restart mid-program.
//  - CycleCnt increments on every RUN cycle, including stall and halt cycles.
//      It saturates at all-ones and does not wrap.
//  - HALTED:
//      PC, CycleCnt and Done=1 are held.
//      Start=1 -> same action as Start in IDLE: load PROG_BASE[ProgSel], clear CycleCnt,
//      Done drops on the next edge, state RUN.
//  - Latency: Start sampled at edge N -> Valid=1 and InstAddress=base after edge N.
//      The ROM is combinational, so the instruction is available in that same cycle.
//  - ProgSel >= NP: load address 0.
//  - Reset asserted mid-program: returns to IDLE immediately, without waiting for a clock.
// STRUCTURE
//  - fetch_pkg holds:
//      typedef enum logic[1:0] {IDLE,RUN,HALTED} fetch_state_t;
//      localparam logic[A-1:0] PROG_BASE[NP] (defaults 0x0000,0x0100,0x0200,0x0300).
//  - One sub-module, next_pc_calc: combinational priority mux and offset adder
//    (inputs PC and the control signals; output next PC).
//  - The top level holds only the state register, PC register and counter.
// TESTING
//  1 Reset_n=0 mid-RUN at PC=0x0042 -> asynchronously PC=0, Valid=0, Done=0, CycleCnt=0.
//  2 Start with ProgSel=1, then 3 free cycles ->
//      InstAddress 0x0100,0x0101,0x0102,0x0103; Valid=1.
//  3 At PC=0x0105:
//      BranchOff=0xFB (-5) -> 0x0100.
//      BranchOff=0x7F      -> 0x0184.
//      Jump and branch together, JumpAddr=0x0020 -> 0x0020.
//  4 At PC=0x0010:
//      Stall=1 for 3 cycles with BranchEn=1 -> PC holds 0x0010.
//      Release -> 0x0011. CycleCnt advanced by 4.
//  5 JumpAddr=0xFFFF, then a free cycle -> PC=0x0000 (wrap); Valid stays 1.
//  6 HaltReq at PC=0x0007 -> Done=1 next edge, PC holds 0x0007, CycleCnt frozen.
//      Start with ProgSel=2 -> PC=0x0200, Done=0, CycleCnt=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and program base table for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {IDLE, RUN, HALTED} fetch_state_t;

  localparam int unsigned FETCH_AW = 16;
  localparam int unsigned FETCH_NP = 4;

  localparam logic [FETCH_AW-1:0] PROG_BASE [FETCH_NP] = '{
    16'h0000, 16'h0100, 16'h0200, 16'h0300
  };

  // Out-of-range selections fall back to address 0.
  function automatic logic [FETCH_AW-1:0] prog_base(input int unsigned sel);
    logic [FETCH_AW-1:0] base;
    base = '0;
    for (int unsigned i = 0; i < FETCH_NP; i++) begin
      if (sel == i) base = PROG_BASE[i];
    end
    return base;
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC priority mux: halt/stall hold, then jump, branch, increment.
module next_pc_calc #(
  parameter int unsigned A  = 16,
  parameter int unsigned OW = 8
) (
  input  logic [A-1:0]  pc_i,
  input  logic          halt_req_i,
  input  logic          stall_i,
  input  logic          jump_en_i,
  input  logic [A-1:0]  jump_addr_i,
  input  logic          branch_en_i,
  input  logic [OW-1:0] branch_off_i,
  output logic [A-1:0]  next_pc_o
);

  logic [A-1:0] off_sext;

  assign off_sext = {{(A - OW){branch_off_i[OW-1]}}, branch_off_i};

  always_comb begin
    next_pc_o = pc_i + 1'b1;
    if (halt_req_i || stall_i) begin
      next_pc_o = pc_i;
    end else if (jump_en_i) begin
      next_pc_o = jump_addr_i;
    end else if (branch_en_i) begin
      next_pc_o = pc_i + off_sext;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Program counter and fetch-control FSM feeding the combinational instruction ROM.
module inst_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned A  = 16,
  parameter int unsigned OW = 8,
  parameter int unsigned NP = 4,
  parameter int unsigned CW = 16
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  Start,
  input  logic [$clog2(NP)-1:0] ProgSel,
  input  logic                  Stall,
  input  logic                  BranchEn,
  input  logic [OW-1:0]         BranchOff,
  input  logic                  JumpEn,
  input  logic [A-1:0]          JumpAddr,
  input  logic                  HaltReq,
  output logic [A-1:0]          InstAddress,
  output logic                  Valid,
  output logic                  Done,
  output logic [CW-1:0]         CycleCnt
);

  fetch_state_t state_q, state_d;
  logic [A-1:0]  pc_q, pc_d, run_pc, start_pc;
  logic [CW-1:0] cnt_q, cnt_d;

  assign start_pc = A'(prog_base(32'(ProgSel)));

  next_pc_calc #(
    .A  (A),
    .OW (OW)
  ) u_next_pc_calc (
    .pc_i         (pc_q),
    .halt_req_i   (HaltReq),
    .stall_i      (Stall),
    .jump_en_i    (JumpEn),
    .jump_addr_i  (JumpAddr),
    .branch_en_i  (BranchEn),
    .branch_off_i (BranchOff),
    .next_pc_o    (run_pc)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE, HALTED: begin
        if (Start) begin
          state_d = RUN;
          pc_d    = start_pc;
          cnt_d   = '0;
        end
      end
      RUN: begin
        pc_d  = run_pc;
        // Saturate rather than wrap.
        cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        if (HaltReq) state_d = HALTED;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign InstAddress = pc_q;
  assign Valid       = (state_q == RUN);
  assign Done        = (state_q == HALTED);
  assign CycleCnt    = cnt_q;

endmodule
